fetch_ctrl: RTL and testbench

//   Drives the PC register: produces pc_new/pc_en from the PC register's pc/pc_4.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_redir_buf.sv | 53 +++++
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch controller.
//   - Default address/data widths and watchdog limit.
//   - FSM state encodings (FETCH / OUT / HALT).
//   - Watchdog counter width helper.
package fetch_pkg;

    localparam int unsigned AddrWDef   = 32;
    localparam int unsigned DataWDef   = 32;
    localparam int unsigned TimeoutDef = 255;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t StFetch = 2'd0;  // request outstanding / about to issue
    localparam fetch_state_t StOut   = 2'd1;  // instruction presented to decode
    localparam fetch_state_t StHalt  = 2'd2;  // stopped until reset

    // The counter must hold TIMEOUT. A zero TIMEOUT still needs a legal 1-bit vector.
    function automatic int unsigned wd_cnt_w(input int unsigned timeout);
        int unsigned w;
        if (timeout == 0) begin
            w = 1;
        end else begin
            w = $clog2(timeout + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/fetch_redir_buf.sv
// fetch_redir_buf: one-entry pending-redirect register.
//   A redirect that arrives while a fetch is still outstanding is parked here
//   until the fetch completes. The first redirect wins; later ones are dropped
//   until the entry is cleared.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   set_valid_i     capture set_target_i if the entry is empty
//   set_target_i    redirect PC to capture
//   clear_i         empty the entry (takes priority over set)
//   full_o          entry holds a target
//   target_o        held target
module fetch_redir_buf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_valid_i,
    input  logic [ADDR_W-1:0] set_target_i,
    input  logic              clear_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] target_q, target_d;

    always_comb begin
        full_d   = full_q;
        target_d = target_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (set_valid_i && !full_q) begin
            full_d   = 1'b1;
            target_d = set_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 1'b0;
            target_q <= '0;
        end else begin
            full_q   <= full_d;
            target_q <= target_d;
        end
    end

    assign full_o   = full_q;
    assign target_o = target_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller.
//   Fetches from imem over req/ack at the current PC, hands the word to decode
//   over valid/ready, and steers the external PC register (pc_new/pc_en).
//   Applies redirects from execute, stops on halt, and halts with a sticky
//   error if imem fails to ack within TIMEOUT cycles.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pc, pc_4                    current PC and PC+4 from the PC register
//   pc_new, pc_en               next PC and one-cycle load strobe
//   imem_req/addr/ack/rdata     instruction memory handshake
//   inst, inst_valid, inst_ready decode handshake
//   redir_valid, redir_target   redirect pulse from execute
//   halt                        level request to stop fetching
//   halted                      fetch stopped (halt or timeout)
//   fetch_err                   sticky watchdog timeout flag
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = AddrWDef,
    parameter int unsigned DATA_W  = DataWDef,
    parameter int unsigned TIMEOUT = TimeoutDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_4,
    output logic [ADDR_W-1:0] pc_new,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              halt,
    output logic              halted,
    output logic              fetch_err
);

    localparam int unsigned     CntW    = wd_cnt_w(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam bit              WdEn    = (TIMEOUT != 0);

    fetch_state_t      state_q, state_d;
    logic              run_q;  // low for the cycle(s) rst is held so req stays low
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              fetch_err_q, fetch_err_d;
    logic [CntW-1:0]   wd_cnt_q, wd_cnt_d;

    logic              buf_set, buf_clear, buf_full;
    logic [ADDR_W-1:0] buf_target;

    logic req, ack_hit, waiting, timeout_hit;

    assign req         = run_q && (state_q == StFetch);
    assign ack_hit     = req && imem_ack;
    assign waiting     = req && !imem_ack;
    assign timeout_hit = WdEn && waiting && (wd_cnt_q == CntLast);

    fetch_redir_buf #(
        .ADDR_W (ADDR_W)
    ) u_redir_buf (
        .clk          (clk),
        .rst          (rst),
        .set_valid_i  (buf_set),
        .set_target_i (redir_target),
        .clear_i      (buf_clear),
        .full_o       (buf_full),
        .target_o     (buf_target)
    );

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        fetch_err_d = fetch_err_q;
        wd_cnt_d    = wd_cnt_q;
        buf_set     = 1'b0;
        buf_clear   = 1'b0;
        pc_en       = 1'b0;
        pc_new      = pc_4;

        case (state_q)
            StFetch: begin
                if (ack_hit) begin
                    wd_cnt_d  = '0;
                    buf_clear = 1'b1;
                    if (halt) begin
                        state_d = StHalt;
                    end else if (buf_full || redir_valid) begin
                        // Fetched word is stale; restart at the redirect target.
                        pc_en  = 1'b1;
                        pc_new = buf_full ? buf_target : redir_target;
                    end else begin
                        inst_d  = imem_rdata;
                        state_d = StOut;
                    end
                end else if (waiting) begin
                    if (timeout_hit) begin
                        fetch_err_d = 1'b1;
                        state_d     = StHalt;
                    end else begin
                        wd_cnt_d = wd_cnt_q + CntW'(1);
                        buf_set  = redir_valid;
                    end
                end
            end
            StOut: begin
                if (redir_valid || inst_ready) begin
                    if (halt) begin
                        state_d = StHalt;
                    end else begin
                        pc_en   = 1'b1;
                        pc_new  = redir_valid ? redir_target : pc_4;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            run_q       <= 1'b0;
            inst_q      <= '0;
            fetch_err_q <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            inst_q      <= inst_d;
            fetch_err_q <= fetch_err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign imem_req   = req;
    assign imem_addr  = pc;
    assign inst       = inst_q;
    assign inst_valid = (state_q == StOut);
    assign halted     = (state_q == StHalt);
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_r, pc_4, pc_new, imem_addr, redir_target;
    logic          pc_en, imem_req, imem_ack, inst_valid, inst_ready;
    logic          redir_valid, halt, halted, fetch_err;
    logic [DW-1:0] imem_rdata, inst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // PC register living outside the fetch controller.
    always_ff @(posedge clk) begin
        if (rst) pc_r <= '0;
        else if (pc_en) pc_r <= pc_new;
    end
    assign pc_4 = pc_r + 32'd4;

    fetch_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc_r),
        .pc_4         (pc_4),
        .pc_new       (pc_new),
        .pc_en        (pc_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .halt         (halt),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        inst_ready   = 1'b0;
        redir_valid  = 1'b0;
        redir_target = '0;
        halt         = 1'b0;
    endtask

    // Holds rst for two edges, checks reset values, then releases rst.
    task automatic apply_rst();
        clr_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_pc_en", 64'(pc_en), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_err", 64'(fetch_err), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        rst = 1'b0;
    endtask

    // Reset, then fetch addr 0 with a zero-wait ack; returns in OUT.
    task automatic go_out();
        apply_rst();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    typedef struct {
        logic          ready;
        logic          redir;
        logic          hlt;
        logic [31:0]   tgt;
        logic          e_pc_en;
        logic [31:0]   e_pc_new;
        logic          e_valid;
        logic          e_halted;
        logic          e_req;
    } vec_t;

    vec_t vecs[7];

    // Reference model state for the random run.
    logic          m_run, m_have;
    logic [31:0]   m_pc, m_inst;
    int            m_wait;
    logic [31:0]   pend[$];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic          e_req, e_en, n_have;
        logic [31:0]   e_new, n_inst;

        rst = 1'b1;
        clr_inputs();

        // OUT-state decision table: {ready, redir, halt, target} -> outcome.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h140, 1'b1, 32'h140, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h180, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 1'b0};

        // 1: sequential fetch, ack one cycle after req, ready high.
        apply_rst();
        #1;
        chk("t1_req_low_first", 64'(imem_req), 64'd0);
        inst_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            chk("t1_req", 64'(imem_req), 64'd1);
            chk("t1_addr", 64'(imem_addr), 64'(a));
            chk("t1_no_pc_en_wait", 64'(pc_en), 64'd0);
            tick();
            imem_ack   = 1'b1;
            imem_rdata = word(a);
            #1;
            chk("t1_no_pc_en_ack", 64'(pc_en), 64'd0);
            tick();
            imem_ack = 1'b0;
            #1;
            chk("t1_valid", 64'(inst_valid), 64'd1);
            chk("t1_inst", 64'(inst), 64'(word(a)));
            chk("t1_pc_en", 64'(pc_en), 64'd1);
            chk("t1_pc_new", 64'(pc_new), 64'(a + 32'd4));
            chk("t1_req_out", 64'(imem_req), 64'd0);
            tick();
        end

        // 2: decode backpressure for 5 cycles.
        go_out();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_valid", 64'(inst_valid), 64'd1);
            chk("t2_inst", 64'(inst), 64'(word(32'h0)));
            chk("t2_pc_en", 64'(pc_en), 64'd0);
            chk("t2_req", 64'(imem_req), 64'd0);
            tick();
        end
        inst_ready = 1'b1;
        #1;
        chk("t2_pc_en_rdy", 64'(pc_en), 64'd1);
        chk("t2_pc_new", 64'(pc_new), 64'h4);
        tick();
        inst_ready = 1'b0;
        chk("t2_next_addr", 64'(imem_addr), 64'h4);
        chk("t2_next_req", 64'(imem_req), 64'd1);
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        tick();
        imem_ack = 1'b0;

        // 3: redirect to 0x100 while holding an instruction.
        redir_valid  = 1'b1;
        redir_target = 32'h100;
        #1;
        chk("t3_pc_en", 64'(pc_en), 64'd1);
        chk("t3_pc_new", 64'(pc_new), 64'h100);
        tick();
        redir_valid = 1'b0;
        chk("t3_valid_drop", 64'(inst_valid), 64'd0);
        chk("t3_req", 64'(imem_req), 64'd1);
        chk("t3_addr", 64'(imem_addr), 64'h100);

        // 4: two redirects during a 4-cycle wait; first wins, data dropped.
        for (int i = 0; i < 4; i++) begin
            redir_valid  = (i == 0) || (i == 2);
            redir_target = (i == 0) ? 32'h200 : 32'h300;
            #1;
            chk("t4_wait_pc_en", 64'(pc_en), 64'd0);
            chk("t4_wait_addr", 64'(imem_addr), 64'h100);
            tick();
        end
        redir_valid = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = word(imem_addr);
        #1;
        chk("t4_pc_en", 64'(pc_en), 64'd1);
        chk("t4_pc_new", 64'(pc_new), 64'h200);
        tick();
        imem_ack = 1'b0;
        chk("t4_valid", 64'(inst_valid), 64'd0);
        chk("t4_addr", 64'(imem_addr), 64'h200);
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        #1;
        chk("t4_no_second_redir", 64'(pc_en), 64'd0);
        tick();
        imem_ack = 1'b0;
        chk("t4_inst", 64'(inst), 64'(word(32'h200)));
        chk("t4_valid2", 64'(inst_valid), 64'd1);

        // 5 + table: OUT-state decisions, including halt with redirect.
        for (int v = 0; v < 7; v++) begin
            go_out();
            inst_ready   = vecs[v].ready;
            redir_valid  = vecs[v].redir;
            halt         = vecs[v].hlt;
            redir_target = vecs[v].tgt;
            #1;
            chk("tab_pc_en", 64'(pc_en), 64'(vecs[v].e_pc_en));
            if (vecs[v].e_pc_en) chk("tab_pc_new", 64'(pc_new), 64'(vecs[v].e_pc_new));
            tick();
            inst_ready  = 1'b0;
            redir_valid = 1'b0;
            chk("tab_valid", 64'(inst_valid), 64'(vecs[v].e_valid));
            chk("tab_halted", 64'(halted), 64'(vecs[v].e_halted));
            chk("tab_req", 64'(imem_req), 64'(vecs[v].e_req));
            chk("tab_addr", 64'(imem_addr), vecs[v].e_pc_en ? 64'(vecs[v].e_pc_new) : 64'd0);
            if (vecs[v].e_halted) begin
                for (int i = 0; i < 3; i++) begin
                    inst_ready   = 1'b1;
                    redir_valid  = 1'b1;
                    redir_target = 32'h400;
                    imem_ack     = 1'b1;
                    #1;
                    chk("halt_req", 64'(imem_req), 64'd0);
                    chk("halt_pc_en", 64'(pc_en), 64'd0);
                    chk("halt_halted", 64'(halted), 64'd1);
                    tick();
                end
            end
            clr_inputs();
        end

        // 6: watchdog with ack never arriving.
        apply_rst();
        tick();
        for (int k = 1; k <= int'(TO); k++) begin
            chk("t6_req_wait", 64'(imem_req), 64'd1);
            chk("t6_err_low", 64'(fetch_err), 64'd0);
            tick();
        end
        chk("t6_err", 64'(fetch_err), 64'd1);
        chk("t6_halted", 64'(halted), 64'd1);
        chk("t6_req_low", 64'(imem_req), 64'd0);
        imem_ack = 1'b1;
        tick();
        chk("t6_err_sticky", 64'(fetch_err), 64'd1);
        chk("t6_halt_pc_en", 64'(pc_en), 64'd0);
        apply_rst();

        // 6 cont.: reset in the middle of a wait with a redirect parked.
        tick();
        redir_valid  = 1'b1;
        redir_target = 32'h500;
        tick();
        redir_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6r_req", 64'(imem_req), 64'd0);
        chk("t6r_valid", 64'(inst_valid), 64'd0);
        chk("t6r_pc_en", 64'(pc_en), 64'd0);
        chk("t6r_halted", 64'(halted), 64'd0);
        chk("t6r_err", 64'(fetch_err), 64'd0);
        rst = 1'b0;
        tick();
        chk("t6r_req_again", 64'(imem_req), 64'd1);
        chk("t6r_addr", 64'(imem_addr), 64'd0);
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        #1;
        chk("t6r_pend_cleared", 64'(pc_en), 64'd0);
        tick();
        imem_ack = 1'b0;
        chk("t6r_inst", 64'(inst), 64'(word(32'h0)));

        // Random run against a transaction-level model.
        apply_rst();
        m_run  = 1'b0;
        m_have = 1'b0;
        m_pc   = '0;
        m_inst = '0;
        m_wait = 0;
        pend.delete();
        for (int c = 0; c < 800; c++) begin
            imem_ack     = ($urandom_range(0, 2) == 0) || (m_wait >= 4);
            inst_ready   = 1'($urandom_range(0, 1));
            redir_valid  = ($urandom_range(0, 7) == 0);
            redir_target = 32'($urandom_range(0, 1023)) << 2;
            imem_rdata   = imem_ack ? word(imem_addr) : $urandom;
            #1;
            e_req  = m_run && !m_have;
            e_en   = 1'b0;
            e_new  = '0;
            n_have = m_have;
            n_inst = m_inst;
            if (e_req && imem_ack) begin
                if (pend.size() > 0) begin
                    e_en  = 1'b1;
                    e_new = pend[0];
                end else if (redir_valid) begin
                    e_en  = 1'b1;
                    e_new = redir_target;
                end else begin
                    n_have = 1'b1;
                    n_inst = word(m_pc);
                end
                pend.delete();
            end else if (e_req) begin
                if (redir_valid) pend.push_back(redir_target);
            end else if (m_have) begin
                if (redir_valid) begin
                    e_en   = 1'b1;
                    e_new  = redir_target;
                    n_have = 1'b0;
                end else if (inst_ready) begin
                    e_en   = 1'b1;
                    e_new  = m_pc + 32'd4;
                    n_have = 1'b0;
                end
            end
            chk("rnd_req", 64'(imem_req), 64'(e_req));
            chk("rnd_valid", 64'(inst_valid), 64'(m_have));
            chk("rnd_pc_en", 64'(pc_en), 64'(e_en));
            if (e_req) chk("rnd_addr", 64'(imem_addr), 64'(m_pc));
            if (m_have) chk("rnd_inst", 64'(inst), 64'(m_inst));
            if (e_en) chk("rnd_pc_new", 64'(pc_new), 64'(e_new));
            m_wait = (e_req && !imem_ack) ? m_wait + 1 : 0;
            if (e_en) m_pc = e_new;
            m_have = n_have;
            m_inst = n_inst;
            m_run  = 1'b1;
            tick();
        end
        chk("rnd_never_halted", 64'(halted), 64'd0);
        chk("rnd_no_err", 64'(fetch_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
